// File: rtl/rsa_pkg.sv
// Shared widths and FSM state encoding for the RSA byte-stream controller.
package rsa_pkg;

    localparam int unsigned RSA_W     = 256;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned RSA_BYTES = RSA_W / BYTE_W;
    localparam int unsigned CNT_W     = $clog2(RSA_BYTES);

    typedef enum logic [2:0] {
        S_GET_N = 3'd0,
        S_GET_D = 3'd1,
        S_GET_A = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_SEND  = 3'd5
    } rsa_stream_state_t;

endpackage

// File: rtl/rsa_byte_deser.sv
// MSB-first byte deserializer: shifts accepted bytes into a RSA_W-bit word and
// flags the byte that completes the word (o_full_c), clearing its counter.
module rsa_byte_deser
    import rsa_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_data,
    output logic [RSA_W-1:0]  o_word_c,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full_c
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSA_BYTES - 1);

    logic [RSA_W-1:0] r_sh;
    logic [CNT_W-1:0] r_cnt;

    // Word including the byte being accepted this cycle
    assign o_word_c = (r_sh << BYTE_W) | RSA_W'(i_data);
    assign o_full_c = i_load && (r_cnt == CNT_LAST);
    assign o_count  = r_cnt;

    // Shift register and byte counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= o_word_c;
            r_cnt <= o_full_c ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rsa_stream_ctrl.sv
// Byte-stream front/back end for the RSA decryption core: loads N, d and
// ciphertext blocks, starts the core, then streams the plaintext out MSB-first.
// Build option RSA_STREAM_FULLOUT_EN: send all 32 result bytes instead of the
// low 31 (default drops bits 255:248).
module rsa_stream_ctrl
    import rsa_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [BYTE_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [BYTE_W-1:0] o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    input  logic              i_key_reload,
    output logic              o_core_start,
    output logic [RSA_W-1:0]  o_core_n,
    output logic [RSA_W-1:0]  o_core_d,
    output logic [RSA_W-1:0]  o_core_a,
    input  logic [RSA_W-1:0]  i_core_result,
    input  logic              i_core_finished,
    output logic              o_busy
);

`ifdef RSA_STREAM_FULLOUT_EN
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(RSA_BYTES - 1);
`else
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(RSA_BYTES - 2);
`endif

    rsa_stream_state_t r_state, w_state_nxt;

    logic [RSA_W-1:0] r_n, r_d, r_a, r_tx_sh;
    logic [RSA_W-1:0] w_word, w_tx_load;
    logic [CNT_W-1:0] w_rx_cnt, r_tx_cnt;
    logic             w_full, w_load, w_rx_ready;
    logic             w_latch, w_tx_accept;
    logic             r_wait_armed, r_core_start, r_busy, r_tx_valid;

    // Shared deserializer for N, d and a
    rsa_byte_deser u_deser (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_load),
        .i_data   (i_rx_data),
        .o_word_c (w_word),
        .o_count  (w_rx_cnt),
        .o_full_c (w_full)
    );

    assign w_load = w_rx_ready && i_rx_valid;

`ifdef RSA_STREAM_FULLOUT_EN
    assign w_tx_load = i_core_result;
`else
    assign w_tx_load = i_core_result << BYTE_W;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_GET_N;
        else       r_state <= w_state_nxt;
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_rx_ready  = 1'b0;
        w_latch     = 1'b0;
        w_tx_accept = 1'b0;
        case (r_state)
            S_GET_N: begin
                w_rx_ready = 1'b1;
                if (w_full) w_state_nxt = S_GET_D;
            end
            S_GET_D: begin
                w_rx_ready = 1'b1;
                if (w_full) w_state_nxt = S_GET_A;
            end
            S_GET_A: begin
                if ((w_rx_cnt == '0) && i_key_reload) begin
                    w_state_nxt = S_GET_N;
                end else begin
                    w_rx_ready = 1'b1;
                    if (w_full) w_state_nxt = S_START;
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // First WAIT cycle may still see the previous run's sticky flag
                if (r_wait_armed && i_core_finished) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (i_tx_ready) begin
                    w_tx_accept = 1'b1;
                    if (r_tx_cnt == TX_LAST) w_state_nxt = S_GET_A;
                end
            end
            default: w_state_nxt = S_GET_N;
        endcase
    end

    // Operand registers, tx shifter and registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_n          <= '0;
            r_d          <= '0;
            r_a          <= '0;
            r_tx_sh      <= '0;
            r_tx_cnt     <= '0;
            r_wait_armed <= 1'b0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_tx_valid   <= 1'b0;
        end else begin
            r_wait_armed <= (r_state == S_WAIT);
            r_core_start <= (w_state_nxt == S_START);
            r_busy       <= (w_state_nxt == S_START) || (w_state_nxt == S_WAIT) ||
                            (w_state_nxt == S_SEND);
            r_tx_valid   <= (w_state_nxt == S_SEND);
            if (w_full) begin
                case (r_state)
                    S_GET_N: r_n <= w_word;
                    S_GET_D: r_d <= w_word;
                    S_GET_A: r_a <= w_word;
                    default: ;
                endcase
            end
            if (w_latch) begin
                r_tx_sh  <= w_tx_load;
                r_tx_cnt <= '0;
            end else if (w_tx_accept) begin
                r_tx_sh  <= r_tx_sh << BYTE_W;
                r_tx_cnt <= (r_tx_cnt == TX_LAST) ? '0 : r_tx_cnt + CNT_W'(1);
            end
        end
    end

    assign o_rx_ready   = w_rx_ready;
    assign o_tx_data    = r_tx_sh[RSA_W-1 -: BYTE_W];
    assign o_tx_valid   = r_tx_valid;
    assign o_core_start = r_core_start;
    assign o_core_n     = r_n;
    assign o_core_d     = r_d;
    assign o_core_a     = r_a;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Bench for rsa_stream_ctrl: behavioural RSA core plus a byte scoreboard.
module tb_rsa_stream_ctrl;
    import rsa_pkg::*;

`ifdef RSA_STREAM_FULLOUT_EN
    localparam int TX_BYTES = 32;
`else
    localparam int TX_BYTES = 31;
`endif
    localparam int CORE_LAT = 12;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic [BYTE_W-1:0] i_rx_data = '0;
    logic              i_rx_valid = 1'b0;
    logic              o_rx_ready;
    logic [BYTE_W-1:0] o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready = 1'b0;
    logic              i_key_reload = 1'b0;
    logic              o_core_start;
    logic [RSA_W-1:0]  o_core_n, o_core_d, o_core_a;
    logic [RSA_W-1:0]  i_core_result = '0;
    logic              i_core_finished = 1'b0;
    logic              o_busy;

    int checks = 0;
    int errors = 0;
    int start_cycles = 0;
    int core_cnt = 0;
    logic core_clr = 1'b0;
    logic [7:0] exp_q[$];

    rsa_stream_ctrl dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_rx_data       (i_rx_data),
        .i_rx_valid      (i_rx_valid),
        .o_rx_ready      (o_rx_ready),
        .o_tx_data       (o_tx_data),
        .o_tx_valid      (o_tx_valid),
        .i_tx_ready      (i_tx_ready),
        .i_key_reload    (i_key_reload),
        .o_core_start    (o_core_start),
        .o_core_n        (o_core_n),
        .o_core_d        (o_core_d),
        .o_core_a        (o_core_a),
        .i_core_result   (i_core_result),
        .i_core_finished (i_core_finished),
        .o_busy          (o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [RSA_W-1:0] modexp(input longint unsigned b_in,
                                                input longint unsigned e_in,
                                                input longint unsigned m);
        longint unsigned r, b, e;
        if (m == 0) return '0;
        r = 1; b = b_in % m; e = e_in;
        while (e > 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return RSA_W'(r);
    endfunction

    // Behavioural core: stale finished flag lingers one cycle after start with junk result
    always @(posedge i_clk) begin
        if (o_core_start) start_cycles <= start_cycles + 1;
        if (i_rst) begin
            core_cnt        <= 0;
            core_clr        <= 1'b0;
            i_core_finished <= 1'b0;
        end else begin
            if (core_clr) begin
                i_core_finished <= 1'b0;
                core_clr        <= 1'b0;
            end
            if (o_core_start) begin
                core_clr      <= 1'b1;
                core_cnt      <= CORE_LAT;
                i_core_result <= '1;
            end else if (core_cnt > 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) begin
                    i_core_result   <= modexp(o_core_a[31:0], o_core_d[31:0], o_core_n[31:0]);
                    i_core_finished <= 1'b1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        #1;
        while (!o_rx_ready && t < 200) begin
            @(negedge i_clk); #1;
            t++;
        end
        if (t >= 200) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout: byte %h never accepted", b);
        end
        @(posedge i_clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_block(input logic [RSA_W-1:0] v);
        for (int i = 0; i < 32; i++) send_byte(v[RSA_W-1-8*i -: 8]);
    endtask

    task automatic push_expected(input logic [RSA_W-1:0] n, input logic [RSA_W-1:0] d,
                                 input logic [RSA_W-1:0] a);
        logic [RSA_W-1:0] res;
        res = modexp(a[31:0], d[31:0], n[31:0]);
        for (int i = TX_BYTES - 1; i >= 0; i--) exp_q.push_back(res[8*i +: 8]);
    endtask

    task automatic recv_tx(input int stall_at, input int stall_len);
        logic [7:0] held, exp_b;
        for (int idx = 0; idx < TX_BYTES; idx++) begin
            int t = 0;
            @(negedge i_clk);
            while (!o_tx_valid && t < 2000) begin
                @(negedge i_clk);
                t++;
            end
            if (t >= 2000) begin
                checks++; errors++;
                $display("FAIL tx_valid_timeout: byte %0d never offered", idx);
                return;
            end
            if (idx == stall_at) begin
                held = o_tx_data;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge i_clk);
                    checks++;
                    if (o_tx_valid !== 1'b1 || o_tx_data !== held) begin
                        errors++;
                        $display("FAIL tx_stall_stable: valid=%b data=%h, need valid=1 data=%h",
                                 o_tx_valid, o_tx_data, held);
                    end
                end
            end
            exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (o_tx_data !== exp_b) begin
                errors++;
                $display("FAIL tx_byte[%0d]: got %h, need %h", idx, o_tx_data, exp_b);
            end
            i_tx_ready = 1'b1;
            @(posedge i_clk); #1;
            i_tx_ready = 1'b0;
        end
        @(negedge i_clk);
        checks++;
        if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL tx_end: valid=%b busy=%b after last byte, need 0 0", o_tx_valid, o_busy);
        end
    endtask

    task automatic run_txn(input logic [RSA_W-1:0] n, input logic [RSA_W-1:0] d,
                           input logic [RSA_W-1:0] a, input int stall_at, input int stall_len);
        int s0;
        s0 = start_cycles;
        push_expected(n, d, a);
        send_block(a);
        recv_tx(stall_at, stall_len);
        checks++;
        if (start_cycles !== s0 + 1) begin
            errors++;
            $display("FAIL start_pulse: %0d start cycles, need 1", start_cycles - s0);
        end
        checks++;
        if (o_core_n !== n || o_core_d !== d || o_core_a !== a) begin
            errors++;
            $display("FAIL operands: n=%h d=%h a=%h, need n=%h d=%h a=%h",
                     o_core_n[31:0], o_core_d[31:0], o_core_a[31:0], n[31:0], d[31:0], a[31:0]);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d bytes, need 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (o_busy !== 1'b0 || o_tx_valid !== 1'b0 || o_tx_data !== 8'h00 ||
            o_core_start !== 1'b0 || o_core_n !== '0 || o_core_d !== '0 || o_core_a !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b txv=%b txd=%h start=%b n|d|a nonzero=%b, need all 0",
                     tag, o_busy, o_tx_valid, o_tx_data, o_core_start,
                     |{o_core_n, o_core_d, o_core_a});
        end
        checks++;
        if (o_rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_rx_ready: got %b, need 1", tag, o_rx_ready);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check_idle("reset");
    endtask

    task automatic test_basic(input logic [RSA_W-1:0] n, input logic [RSA_W-1:0] d,
                              input logic [RSA_W-1:0] a);
        send_block(n);
        send_block(d);
        run_txn(n, d, a, -1, 0);
    endtask

    task automatic test_stall(input logic [RSA_W-1:0] n, input logic [RSA_W-1:0] d,
                              input logic [RSA_W-1:0] a);
        run_txn(n, d, a, 10, 5);
    endtask

    task automatic test_back_to_back(input logic [RSA_W-1:0] n, input logic [RSA_W-1:0] d,
                                     input logic [RSA_W-1:0] a);
        run_txn(n, d, a, -1, 0);
    endtask

    task automatic test_reload(input logic [RSA_W-1:0] n2, input logic [RSA_W-1:0] d2,
                               input logic [RSA_W-1:0] a);
        @(negedge i_clk);
        i_rx_valid   = 1'b1;
        i_rx_data    = 8'hAA;
        i_key_reload = 1'b1;
        #1;
        checks++;
        if (o_rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reload_rx_ready: got %b, need 0", o_rx_ready);
        end
        @(posedge i_clk); #1;
        i_rx_valid   = 1'b0;
        i_key_reload = 1'b0;
        send_block(n2);
        send_block(d2);
        run_txn(n2, d2, a, -1, 0);
    endtask

    task automatic test_reset_mid(input logic [RSA_W-1:0] n, input logic [RSA_W-1:0] d,
                                  input logic [RSA_W-1:0] a);
        int s0, t;
        s0 = start_cycles;
        send_block(a);
        t = 0;
        while (start_cycles == s0 && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL reset_mid_start: no start within 200 cycles");
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy: got %b before reset, need 1", o_busy);
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check_idle("reset_mid");
        test_basic(n, d, a);
    endtask

    initial begin
        logic [RSA_W-1:0] n1, d1, a1, n2, d2;
        n1 = RSA_W'(187);
        d1 = RSA_W'(23);
        a1 = RSA_W'(11);
        n2 = RSA_W'(143);
        d2 = RSA_W'(103);
        test_reset();
        test_basic(n1, d1, a1);
        test_stall(n1, d1, a1);
        test_back_to_back(n1, d1, a1);
        test_reload(n2, d2, a1);
        test_reset_mid(n1, d1, a1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
